// File: rtl/seq_gen_if.sv
// seq_gen_if: load/data handshake and serial output bundle for seq_gen.
// master drives load/data; slave (seq_gen) drives ready/out/out_valid/last/busy.
interface seq_gen_if #(
    parameter int WIDTH = 16
) ();
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             last;
    logic             busy;

    modport master (
        output load, data,
        input  ready, out, out_valid, last, busy
    );

    modport slave (
        input  load, data,
        output ready, out, out_valid, last, busy
    );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serialises a WIDTH-bit word LSB first with a valid qualifier,
// optional even-parity bit (SEQ_GEN_PARITY_EN) and GAP idle cycles per frame.
// Ports: clock, reset (async, active-low), bus (seq_gen_if.slave).
module seq_gen #(
    parameter int WIDTH = 16,
    parameter int GAP   = 1
) (
    input  logic       clock,
    input  logic       reset,
    seq_gen_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;
`endif

    state_e           state_q, state_d;
    // bit 0 goes straight to the output register, so only bits 1.. are kept
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
`ifdef SEQ_GEN_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    shreg_d = bus.data[WIDTH-1:1];
                    out_d   = bus.data[0];
                    valid_d = 1'b1;
                    cnt_d   = '0;
`ifdef SEQ_GEN_PARITY_EN
                    par_d   = ^bus.data;
`endif
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    shreg_d = shreg_q >> 1;
                    out_d   = shreg_q[0];
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
`ifndef SEQ_GEN_PARITY_EN
                    // next bit presented is the final data bit
                    last_d  = (cnt_q == CNT_PEN);
`endif
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    out_d   = par_q;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = S_PAR;
`else
                    gcnt_d  = '0;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PAR: begin
                gcnt_d  = '0;
                state_d = (GAP > 0) ? S_GAP : S_IDLE;
            end
`endif
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.last      = last_q;
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: scoreboard bench for seq_gen, one instance with GAP=1 and
// one with GAP=0 for back-to-back frames.
module tb_seq_gen;
    localparam int W = 16;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clock = 1'b0;
    logic rst1_n = 1'b1;
    logic rst0_n = 1'b1;
    always #5 clock = ~clock;

    seq_gen_if #(.WIDTH(W)) bus1 ();
    seq_gen_if #(.WIDTH(W)) bus0 ();

    seq_gen #(.WIDTH(W), .GAP(1)) u_dut1 (
        .clock (clock),
        .reset (rst1_n),
        .bus   (bus1)
    );

    seq_gen #(.WIDTH(W), .GAP(0)) u_dut0 (
        .clock (clock),
        .reset (rst0_n),
        .bus   (bus0)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] q1[$];
    logic [1:0] q0[$];
    logic [1:0] e1, e0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {last, bit} for frame position i
    function automatic logic [1:0] exp_bit(input logic [W-1:0] d, input int i);
        logic [1:0] r;
        if (i < W) r = {(i == W - 1) && (PB == 0), d[i]};
        else       r = {1'b1, ^d};
        return r;
    endfunction

    function automatic void push1(input logic [W-1:0] d);
        for (int i = 0; i < W + PB; i++) q1.push_back(exp_bit(d, i));
    endfunction

    function automatic void push0(input logic [W-1:0] d);
        for (int i = 0; i < W + PB; i++) q0.push_back(exp_bit(d, i));
    endfunction

    always @(posedge clock) begin
        #1;
        check("valid1", bus1.out_valid, q1.size() != 0);
        if (bus1.out_valid && q1.size() != 0) begin
            e1 = q1.pop_front();
            check("bit1", bus1.out, e1[0]);
            check("last1", bus1.last, e1[1]);
        end else if (!bus1.out_valid) begin
            check("idle_out1", {bus1.out, bus1.last}, 0);
        end
    end

    always @(posedge clock) begin
        #1;
        check("valid0", bus0.out_valid, q0.size() != 0);
        if (bus0.out_valid && q0.size() != 0) begin
            e0 = q0.pop_front();
            check("bit0", bus0.out, e0[0]);
            check("last0", bus0.last, e0[1]);
        end else if (!bus0.out_valid) begin
            check("idle_out0", {bus0.out, bus0.last}, 0);
        end
    end

    task automatic reset_outs1(input string tag);
        check({tag, "_ready"}, bus1.ready, 1);
        check({tag, "_busy"}, bus1.busy, 0);
        check({tag, "_out"}, bus1.out, 0);
        check({tag, "_valid"}, bus1.out_valid, 0);
        check({tag, "_last"}, bus1.last, 0);
    endtask

    task automatic send1(input logic [W-1:0] d, input bit glitch);
        int n;
        n = 0;
        @(negedge clock);
        check("pre_ready1", bus1.ready, 1);
        check("pre_busy1", bus1.busy, 0);
        bus1.load = 1'b1;
        bus1.data = d;
        push1(d);
        @(negedge clock);
        bus1.load = 1'b0;
        bus1.data = ~d;
        while (!bus1.ready && n < 100) begin
            n++;
            if (glitch && n == 5) begin
                bus1.load = 1'b1;
                bus1.data = 16'hFFFF;
            end else begin
                bus1.load = 1'b0;
            end
            @(negedge clock);
        end
        bus1.load = 1'b0;
        check("busy_len1", n, W + PB + 1);
        check("drain1", q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c_first;
        int c_last;
        logic [W-1:0] w;
        bus1.load = 1'b0;
        bus1.data = '0;
        bus0.load = 1'b0;
        bus0.data = '0;
        #1;
        rst1_n = 1'b0;
        rst0_n = 1'b0;
        #2;
        reset_outs1("rst");
        repeat (3) @(negedge clock);
        rst1_n = 1'b1;
        rst0_n = 1'b1;

        send1(16'b0101101101110010, 1'b0);
        send1(16'h0000, 1'b1);
        repeat (25) @(negedge clock);

        // abandon a frame at bit 7
        @(negedge clock);
        check("pre_ready_r", bus1.ready, 1);
        bus1.load = 1'b1;
        bus1.data = 16'hFFFF;
        push1(16'hFFFF);
        @(negedge clock);
        bus1.load = 1'b0;
        repeat (7) @(negedge clock);
        #2;
        rst1_n = 1'b0;
        q1.delete();
        #1;
        reset_outs1("midrst");
        @(negedge clock);
        rst1_n = 1'b1;
        send1(16'h0001, 1'b0);

        // back-to-back with load held high
        n = 0;
        c_first = 0;
        c_last = 0;
        for (int c = 0; c < 300 && n < 4; c++) begin
            @(negedge clock);
            if (bus0.ready) begin
                w = n[0] ? 16'h5555 : 16'hAAAA;
                bus0.load = 1'b1;
                bus0.data = w;
                push0(w);
                if (n == 0) c_first = c;
                c_last = c;
                n++;
            end
        end
        @(negedge clock);
        bus0.load = 1'b0;
        check("frames0", n, 4);
        check("period0", c_last - c_first, 3 * (W + PB + 1));
        repeat (W + PB + 5) @(negedge clock);
        check("drain0", q0.size(), 0);
        check("end_ready0", bus0.ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
